// File: rtl/image_addresser_gen_pkg.sv
// Shared types and width helpers for the parametrised image addresser.
// Package name nabp_ia_pkg is kept for compatibility with the other NABP blocks.
package nabp_ia_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      SCAN_X = 2'd2,
      SCAN_Y = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      MODE_XY = 2'd0,
      MODE_X  = 2'd1,
      MODE_Y  = 2'd2
   } mode_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) result++;
      return result;
   endfunction

   // Counters need at least one bit even when they only ever hold zero.
   function automatic int cnt_width(input int max_count);
      return (clog2(max_count) < 1) ? 1 : clog2(max_count);
   endfunction

   localparam int DEF_IMG_SIZE   = 128;
   localparam int DEF_PART_SIZE  = 16;
   localparam int DEF_PIPE_DELAY = 8;
   localparam int DEF_ADDR_W     = clog2(DEF_IMG_SIZE * DEF_IMG_SIZE);

endpackage

// File: rtl/image_addresser_gen_if.sv
// Host kick / Image RAM port bundle of the image addresser.
// The slave modport is the addresser itself; master is the surrounding host/RAM side.
interface image_addresser_gen_if
   import nabp_ia_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
);

   logic              hs_kick;
   logic [1:0]        hs_mode;
   logic              ir_enable;
   logic              ir_kick;
   logic              ir_valid;
   logic [ADDR_W-1:0] ir_addr;
   logic              ir_axis;
   logic              ir_done;
   logic              busy;

   modport master (
      output hs_kick, hs_mode, ir_enable,
      input  ir_kick, ir_valid, ir_addr, ir_axis, ir_done, busy
   );

   modport slave (
      input  hs_kick, hs_mode, ir_enable,
      output ir_kick, ir_valid, ir_addr, ir_axis, ir_done, busy
   );

endinterface

// File: rtl/image_addresser_gen_wrap_counter.sv
// Modulo-MAX counter with a wrap pulse; 'down' presents the count in reverse
// traversal order so the owner can walk a line backwards without reloading.
module ia_wrap_counter
   import nabp_ia_pkg::*;
#(
   parameter  int MAX = 2,
   localparam int W   = cnt_width(MAX)
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         clear,
   input  logic         enable,
   input  logic         down,
   output logic [W-1:0] value,
   output logic         wrap
);

   localparam logic [W-1:0] TOP = W'(MAX - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!reset_n || clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= (cnt == TOP) ? '0 : cnt + 1'b1;
      end
   end

   assign wrap  = enable && (cnt == TOP);
   assign value = down ? (TOP - cnt) : cnt;

endmodule

// File: rtl/image_addresser.sv
// Image RAM address generator: scans partitions in X/Y order after a PE-chain fill delay.
// Optional macro NABP_IA_SERPENTINE_EN reverses the scan direction on odd lines.
module image_addresser_gen
   import nabp_ia_pkg::*;
#(
   parameter int IMG_SIZE   = DEF_IMG_SIZE,
   parameter int PART_SIZE  = DEF_PART_SIZE,
   parameter int PIPE_DELAY = DEF_PIPE_DELAY
) (
   input logic                  clk,
   input logic                  reset_n,
   image_addresser_gen_if.slave bus
);

   localparam int NO_PARTS = IMG_SIZE / PART_SIZE;
   localparam int ADDR_W   = clog2(IMG_SIZE * IMG_SIZE);
   localparam int LOG_IMG  = clog2(IMG_SIZE);
   localparam int LOG_PART = clog2(PART_SIZE);
   localparam int SW       = cnt_width(IMG_SIZE);
   localparam int LW       = cnt_width(PART_SIZE);
   localparam int PW       = cnt_width(NO_PARTS);
   localparam int DW       = cnt_width(PIPE_DELAY);

   state_t state;
   state_t next_state;
   mode_t  mode_reg;

   logic          clear_cnt;
   logic          scanning;
   logic          delay_en;
   logic          s_en;
   logic          l_en;
   logic          p_en;
   logic          s_down;
   logic          delay_wrap;
   logic          s_wrap;
   logic          l_wrap;
   logic          p_wrap;
   logic [DW-1:0] delay_val;
   logic [SW-1:0] s_val;
   logic [LW-1:0] l_val;
   logic [PW-1:0] p_val;
   logic [ADDR_W-1:0] line_addr;
   logic [ADDR_W-1:0] addr_x;
   logic [ADDR_W-1:0] addr_y;

   assign clear_cnt = (state == IDLE);
   assign scanning  = (state == SCAN_X) || (state == SCAN_Y);
   assign delay_en  = (state == DELAY);
   assign s_en      = scanning && bus.ir_enable;
   assign l_en      = s_wrap;
   // The partition only moves on once every axis of the mode has been scanned.
   assign p_en      = l_wrap && ((state == SCAN_Y) || (mode_reg != MODE_XY));

`ifdef NABP_IA_SERPENTINE_EN
   assign s_down = l_val[0];
`else
   assign s_down = 1'b0;
`endif

   ia_wrap_counter #(.MAX(PIPE_DELAY)) u_delay_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (clear_cnt),
      .enable  (delay_en),
      .down    (1'b0),
      .value   (delay_val),
      .wrap    (delay_wrap)
   );

   ia_wrap_counter #(.MAX(IMG_SIZE)) u_s_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (clear_cnt),
      .enable  (s_en),
      .down    (s_down),
      .value   (s_val),
      .wrap    (s_wrap)
   );

   ia_wrap_counter #(.MAX(PART_SIZE)) u_l_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (clear_cnt),
      .enable  (l_en),
      .down    (1'b0),
      .value   (l_val),
      .wrap    (l_wrap)
   );

   ia_wrap_counter #(.MAX(NO_PARTS)) u_p_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (clear_cnt),
      .enable  (p_en),
      .down    (1'b0),
      .value   (p_val),
      .wrap    (p_wrap)
   );

   // Power-of-two sizes turn the address products into plain shifts and ORs.
   assign line_addr = (ADDR_W'(p_val) << LOG_PART) | ADDR_W'(l_val);
   assign addr_x    = (line_addr << LOG_IMG) | ADDR_W'(s_val);
   assign addr_y    = (ADDR_W'(s_val) << LOG_IMG) | line_addr;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= IDLE;
         mode_reg <= MODE_XY;
      end else begin
         state <= next_state;
         if (state == IDLE && bus.hs_kick) begin
            mode_reg <= (bus.hs_mode == 2'd3) ? MODE_XY : mode_t'(bus.hs_mode);
         end
      end
   end

   always_comb begin
      next_state   = state;
      bus.ir_kick  = 1'b0;
      bus.ir_valid = 1'b0;
      bus.ir_addr  = '0;
      bus.ir_axis  = 1'b0;
      bus.ir_done  = 1'b0;
      bus.busy     = (state != IDLE);
      case (state)
         IDLE: begin
            if (bus.hs_kick) next_state = DELAY;
         end
         DELAY: begin
            bus.ir_kick = delay_wrap;
            if (delay_wrap) next_state = (mode_reg == MODE_Y) ? SCAN_Y : SCAN_X;
         end
         SCAN_X: begin
            bus.ir_valid = 1'b1;
            bus.ir_addr  = addr_x;
            if (p_wrap) begin
               bus.ir_done = 1'b1;
               next_state  = IDLE;
            end else if (l_wrap && mode_reg == MODE_XY) begin
               next_state = SCAN_Y;
            end
         end
         SCAN_Y: begin
            bus.ir_valid = 1'b1;
            bus.ir_axis  = 1'b1;
            bus.ir_addr  = addr_y;
            if (p_wrap) begin
               bus.ir_done = 1'b1;
               next_state  = IDLE;
            end else if (l_wrap) begin
               next_state = (mode_reg == MODE_Y) ? SCAN_Y : SCAN_X;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   logic unused_delay_val;
   assign unused_delay_val = ^delay_val;

endmodule
